// File: rtl/board_uart_tx_pkg.sv
// Shared constants, state types and helpers for the board-state UART transmitter.
package board_uart_tx_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_TWO  = 8'h32;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int unsigned BOARD_BITS      = 192;
  localparam int unsigned SQUARES         = 64;
  localparam int unsigned BITS_PER_SQUARE = 3;
  localparam int unsigned FRAME_BYTES     = 67;

  localparam logic [6:0] LAST_BYTE = 7'(FRAME_BYTES - 1);
  localparam logic [6:0] CR_BYTE   = 7'(SQUARES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } ser_state_e;

  typedef enum logic [1:0] {
    FrIdle,
    FrRun,
    FrDone
  } frame_state_e;

  function automatic logic [7:0] square_ascii(input logic [2:0] code);
    return ASCII_ZERO | {5'b0, code};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with baud counter. ready is also high in the last cycle of
// the stop bit so a new byte can follow with no idle gap.
module uart_tx_byte
  import board_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  ser_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == LastCnt);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (valid) begin
          state_d = StStart;
          cnt_d   = '0;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        cnt_d = cnt_q + 16'd1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        cnt_d = cnt_q + 16'd1;
        ready = bit_end;
        if (bit_end) begin
          cnt_d = '0;
          if (valid) begin
            state_d = StStart;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/board_uart_tx.sv
// Streams a snapshot of turn plus 64 board squares as one ASCII frame
// (turn digit, 64 square digits, CR, LF) over an 8N1 UART line.
module board_uart_tx
  import board_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BOARD_BITS-1:0] serialized_board,
  input  logic                  turn,
  input  logic                  send,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  frame_state_e          state_q, state_d;
  logic [6:0]            idx_q, idx_d;
  logic [BOARD_BITS-1:0] board_q, board_d;
  logic [7:0]            ser_data;
  logic                  ser_valid;
  logic                  ser_ready;
  logic [7:0]            sq_base;
  logic [7:0]            next_byte;

  // Byte idx_q+1 is square idx_q for idx_q in 0..63.
  assign sq_base = {1'b0, idx_q[5:0], 1'b0} + {2'b0, idx_q[5:0]};

  always_comb begin
    next_byte = square_ascii(board_q[sq_base +: BITS_PER_SQUARE]);
    if (idx_q == LAST_BYTE - 7'd1) begin
      next_byte = ASCII_LF;
    end else if (idx_q == CR_BYTE - 7'd1) begin
      next_byte = ASCII_CR;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    board_d   = board_q;
    ser_valid = 1'b0;
    ser_data  = next_byte;
    unique case (state_q)
      FrIdle, FrDone: begin
        state_d = FrIdle;
        // Byte 0 comes straight from the live turn so its start bit follows acceptance.
        if (send) begin
          state_d   = FrRun;
          idx_d     = '0;
          board_d   = serialized_board;
          ser_valid = 1'b1;
          ser_data  = turn ? ASCII_ONE : ASCII_TWO;
        end
      end
      FrRun: begin
        if (ser_ready) begin
          if (idx_q == LAST_BYTE) begin
            state_d = FrDone;
          end else begin
            ser_valid = 1'b1;
            idx_d     = idx_q + 7'd1;
          end
        end
      end
      default: state_d = FrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FrIdle;
      idx_q   <= '0;
      board_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      board_q <= board_d;
    end
  end

  assign busy = (state_q == FrRun);
  assign done = (state_q == FrDone);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_board_uart_tx.sv
// Directed bench for board_uart_tx: records the line cycle by cycle after each
// accepted request and decodes bytes at bit centres.
module tb_board_uart_tx;

  localparam int CPB  = 4;
  localparam int FB   = 67;
  localparam int FCYC = FB * 10 * CPB;
  localparam int CAPN = 2 * FCYC + 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [191:0] board = '0;
  logic         turn = 1'b0;
  logic         send = 1'b0;
  logic         tx, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  logic cap_tx   [0:CAPN-1];
  logic cap_busy [0:CAPN-1];
  logic cap_done [0:CAPN-1];

  always #5 clk = ~clk;

  board_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .serialized_board(board),
    .turn            (turn),
    .send            (send),
    .tx              (tx),
    .busy            (busy),
    .done            (done)
  );

  // Ends 1 time unit after the accepting edge; entry c of the capture is that edge's interval.
  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_tx[c]   = tx;
      cap_busy[c] = busy;
      cap_done[c] = done;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] rx_byte(input int base, input int b);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = cap_tx[base + (b * 10 + 1 + j) * CPB + CPB / 2];
    return v;
  endfunction

  // Bits not held for a full CPB cycles, bad start bits and bad stop bits.
  function automatic int frame_errs(input int base);
    int e = 0;
    for (int b = 0; b < FB; b++) begin
      for (int j = 0; j < 10; j++) begin
        int s = base + (b * 10 + j) * CPB;
        for (int k = 1; k < CPB; k++) if (cap_tx[s + k] !== cap_tx[s]) e++;
        if (j == 0 && cap_tx[s] !== 1'b0) e++;
        if (j == 9 && cap_tx[s] !== 1'b1) e++;
      end
    end
    return e;
  endfunction

  function automatic int count_busy(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (cap_busy[c] === 1'b1) k++;
    return k;
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (cap_done[c] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_done(input int n);
    for (int c = 0; c < n; c++) if (cap_done[c] === 1'b1) return c;
    return -1;
  endfunction

  task automatic test_reset();
    int highs = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tx: got %b expected 1", tx);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0 && done === 1'b0) highs++;
    end
    tests_run++;
    if (highs != 40) begin
      tests_failed++;
      $display("FAIL idle_line: got %0d idle cycles expected 40", highs);
    end
  endtask

  task automatic test_basic_frame();
    int bad_sq = 0;
    board = '0;
    turn  = 1'b1;
    pulse_send();
    capture(FCYC + 4);
    for (int b = 1; b <= 64; b++) if (rx_byte(0, b) !== 8'h30) bad_sq++;
    tests_run++;
    if (rx_byte(0, 0) !== 8'h31) begin
      tests_failed++;
      $display("FAIL basic_byte0: got %h expected 31", rx_byte(0, 0));
    end
    tests_run++;
    if (bad_sq != 0) begin
      tests_failed++;
      $display("FAIL basic_squares: got %0d bad squares expected 0", bad_sq);
    end
    tests_run++;
    if (rx_byte(0, 65) !== 8'h0D || rx_byte(0, 66) !== 8'h0A) begin
      tests_failed++;
      $display("FAIL basic_crlf: got %h %h expected 0d 0a", rx_byte(0, 65), rx_byte(0, 66));
    end
    tests_run++;
    if (frame_errs(0) != 0) begin
      tests_failed++;
      $display("FAIL basic_bit_timing: got %0d errors expected 0", frame_errs(0));
    end
    tests_run++;
    if (first_done(FCYC + 4) != FCYC) begin
      tests_failed++;
      $display("FAIL basic_done_time: got %0d expected %0d", first_done(FCYC + 4), FCYC);
    end
    tests_run++;
    if (count_done(FCYC + 4) != 1) begin
      tests_failed++;
      $display("FAIL basic_done_width: got %0d expected 1", count_done(FCYC + 4));
    end
    tests_run++;
    if (count_busy(FCYC + 4) != FCYC) begin
      tests_failed++;
      $display("FAIL basic_busy_len: got %0d expected %0d", count_busy(FCYC + 4), FCYC);
    end
    tests_run++;
    if (cap_tx[FCYC] !== 1'b1 || cap_tx[FCYC + 3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_tail_idle: got %b%b expected 11", cap_tx[FCYC], cap_tx[FCYC + 3]);
    end
  endtask

  task automatic test_mapping();
    board = '0;
    board[2:0]     = 3'b101;
    board[191:189] = 3'b010;
    board[95:93]   = 3'b111;
    turn = 1'b0;
    pulse_send();
    capture(FCYC + 4);
    tests_run++;
    if (rx_byte(0, 0) !== 8'h32) begin
      tests_failed++;
      $display("FAIL map_byte0: got %h expected 32", rx_byte(0, 0));
    end
    tests_run++;
    if (rx_byte(0, 1) !== 8'h35) begin
      tests_failed++;
      $display("FAIL map_byte1: got %h expected 35", rx_byte(0, 1));
    end
    tests_run++;
    if (rx_byte(0, 32) !== 8'h37) begin
      tests_failed++;
      $display("FAIL map_byte32: got %h expected 37", rx_byte(0, 32));
    end
    tests_run++;
    if (rx_byte(0, 64) !== 8'h32) begin
      tests_failed++;
      $display("FAIL map_byte64: got %h expected 32", rx_byte(0, 64));
    end
    tests_run++;
    if (rx_byte(0, 2) !== 8'h30 || rx_byte(0, 33) !== 8'h30) begin
      tests_failed++;
      $display("FAIL map_neighbours: got %h %h expected 30 30", rx_byte(0, 2), rx_byte(0, 33));
    end
  endtask

  task automatic test_snapshot();
    int bad_sq = 0;
    board = '0;
    turn  = 1'b1;
    pulse_send();
    fork
      capture(FCYC + 4);
      begin
        repeat (5 * 10 * CPB + 6) @(posedge clk);
        #2;
        board = '1;
        turn  = 1'b0;
      end
    join
    for (int b = 1; b <= 64; b++) if (rx_byte(0, b) !== 8'h30) bad_sq++;
    tests_run++;
    if (bad_sq != 0) begin
      tests_failed++;
      $display("FAIL snap_latched: got %0d changed squares expected 0", bad_sq);
    end
    pulse_send();
    capture(FCYC + 4);
    bad_sq = 0;
    for (int b = 1; b <= 64; b++) if (rx_byte(0, b) !== 8'h37) bad_sq++;
    tests_run++;
    if (bad_sq != 0 || rx_byte(0, 0) !== 8'h32) begin
      tests_failed++;
      $display("FAIL snap_second: got %0d bad squares byte0 %h expected 0 and 32", bad_sq,
               rx_byte(0, 0));
    end
  endtask

  task automatic test_collision();
    board = '0;
    turn  = 1'b1;
    pulse_send();
    fork
      capture(FCYC + 4);
      begin
        repeat (20 * 10 * CPB + 10) @(posedge clk);
        #1;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
      end
    join
    tests_run++;
    if (count_done(FCYC + 4) != 1 || count_busy(FCYC + 4) != FCYC) begin
      tests_failed++;
      $display("FAIL collide_ignored: got %0d done %0d busy expected 1 %0d",
               count_done(FCYC + 4), count_busy(FCYC + 4), FCYC);
    end
    tests_run++;
    if (frame_errs(0) != 0 || rx_byte(0, 20) !== 8'h30) begin
      tests_failed++;
      $display("FAIL collide_frame: got %0d errors byte20 %h expected 0 and 30",
               frame_errs(0), rx_byte(0, 20));
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    board = '0;
    turn  = 1'b1;
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    #1;
    capture(2 * FCYC + 2);
    send = 1'b0;
    tests_run++;
    if (cap_done[FCYC] !== 1'b1 || cap_tx[FCYC] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done_cycle: got done %b tx %b expected 1 1", cap_done[FCYC], cap_tx[FCYC]);
    end
    tests_run++;
    if (cap_tx[FCYC + 1] !== 1'b0 || cap_busy[FCYC + 1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_restart: got tx %b busy %b expected 0 1", cap_tx[FCYC + 1],
               cap_busy[FCYC + 1]);
    end
    tests_run++;
    if (rx_byte(FCYC + 1, 0) !== 8'h31 || rx_byte(FCYC + 1, 66) !== 8'h0A ||
        frame_errs(FCYC + 1) != 0) begin
      tests_failed++;
      $display("FAIL b2b_second_frame: got %h %h errs %0d expected 31 0a 0",
               rx_byte(FCYC + 1, 0), rx_byte(FCYC + 1, 66), frame_errs(FCYC + 1));
    end
    tests_run++;
    if (count_done(2 * FCYC + 2) != 2 || first_done(2 * FCYC + 2) != FCYC) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d first at %0d expected 2 at %0d",
               count_done(2 * FCYC + 2), first_done(2 * FCYC + 2), FCYC);
    end
    // A third frame was accepted while send was still held; let it drain.
    while (busy === 1'b1 && waited < FCYC + 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got busy %b after %0d cycles expected 0", busy, waited);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    int dones = 0;
    board = '0;
    turn  = 1'b0;
    pulse_send();
    repeat (10 * 10 * CPB + 1) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_state: got tx %b busy %b done %b expected 1 0 0", tx, busy, done);
    end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || tx !== 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: got %0d active cycles expected 0", dones);
    end
    turn = 1'b1;
    pulse_send();
    capture(FCYC + 4);
    tests_run++;
    if (rx_byte(0, 0) !== 8'h31 || rx_byte(0, 66) !== 8'h0A || frame_errs(0) != 0 ||
        first_done(FCYC + 4) != FCYC) begin
      tests_failed++;
      $display("FAIL midrst_refrm: got %h %h errs %0d done at %0d expected 31 0a 0 %0d",
               rx_byte(0, 0), rx_byte(0, 66), frame_errs(0), first_done(FCYC + 4), FCYC);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mapping();
    test_snapshot();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
